// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the conditional-branch control sequencer:
// state encoding, branch opcode and instruction field positions.
package branch_sequencer_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_T3   = 3'd1;
   localparam logic [2:0] ST_T4   = 3'd2;
   localparam logic [2:0] ST_T5   = 3'd3;
   localparam logic [2:0] ST_T6   = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      T3   = ST_T3,
      T4   = ST_T4,
      T5   = ST_T5,
      T6   = ST_T6,
      ERR  = ST_ERR
   } state_t;

   localparam logic [4:0] BR_OPCODE = 5'b10010;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int C2_MSB  = 22;
   localparam int C2_LSB  = 19;
   localparam int C_MSB   = 18;

   function automatic logic [31:0] sext_c(input logic [31:0] instr);
      return {{(31 - C_MSB){instr[C_MSB]}}, instr[C_MSB:0]};
   endfunction

endpackage

// File: rtl/branch_sequencer.sv
// Sequences brzr/brnz/brpl/brmi through the single-bus datapath: Ra onto the
// bus with CON FF capture, PC + C via Y/ALU/Z, then a conditional PC load.
module branch_sequencer
   import branch_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic        condition,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [3:0]  ra_sel,
   output logic [3:0]  c2,
   output logic [31:0] c_sext,
   output logic        r_out,
   output logic        con_en,
   output logic        pc_out,
   output logic        y_in,
   output logic        c_out,
   output logic        alu_add,
   output logic        z_in,
   output logic        zlo_out,
   output logic        pc_in,
   output logic [2:0]  state_dbg
);

   state_t      state_q, state_d;
   logic [3:0]  ra_sel_q, ra_sel_d;
   logic [3:0]  c2_q, c2_d;
   logic [31:0] c_sext_q, c_sext_d;
   logic        is_branch;

   assign is_branch = (ir[OPC_MSB:OPC_LSB] == BR_OPCODE);

   // start is a level request with no ready: it is accepted only on an edge
   // leaving IDLE or T6, and is silently dropped in T3-T5 and ERR.
   always_comb begin
      state_d  = state_q;
      ra_sel_d = ra_sel_q;
      c2_d     = c2_q;
      c_sext_d = c_sext_q;
      case (state_q)
         IDLE, T6: begin
            if (start && is_branch) begin
               state_d  = T3;
               ra_sel_d = ir[RA_MSB:RA_LSB];
               c2_d     = ir[C2_MSB:C2_LSB];
               c_sext_d = sext_c(ir);
            end else if (start) begin
               state_d = ERR;
            end else begin
               state_d = IDLE;
            end
         end
         T3:      state_d = T4;
         T4:      state_d = T5;
         T5:      state_d = T6;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q  <= IDLE;
         ra_sel_q <= '0;
         c2_q     <= '0;
         c_sext_q <= '0;
      end else begin
         state_q  <= state_d;
         ra_sel_q <= ra_sel_d;
         c2_q     <= c2_d;
         c_sext_q <= c_sext_d;
      end
   end

   // pc_in is the only output that looks past the state: it gates the PC
   // load with the CON FF result captured at the end of T3.
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
      r_out   = 1'b0;
      con_en  = 1'b0;
      pc_out  = 1'b0;
      y_in    = 1'b0;
      c_out   = 1'b0;
      alu_add = 1'b0;
      z_in    = 1'b0;
      zlo_out = 1'b0;
      pc_in   = 1'b0;
      case (state_q)
         T3: begin
            busy   = 1'b1;
            r_out  = 1'b1;
            con_en = 1'b1;
         end
         T4: begin
            busy   = 1'b1;
            pc_out = 1'b1;
            y_in   = 1'b1;
         end
         T5: begin
            busy    = 1'b1;
            c_out   = 1'b1;
            alu_add = 1'b1;
            z_in    = 1'b1;
         end
         T6: begin
            busy    = 1'b1;
            zlo_out = 1'b1;
            done    = 1'b1;
            pc_in   = condition;
         end
         ERR:     illegal = 1'b1;
         default: ;
      endcase
   end

   assign ra_sel    = ra_sel_q;
   assign c2        = c2_q;
   assign c_sext    = c_sext_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: cycle-level reference model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_branch_sequencer;

   logic        clk;
   logic        clear;
   logic        start;
   logic [31:0] ir;
   logic        condition;
   logic        busy, done, illegal;
   logic [3:0]  ra_sel, c2;
   logic [31:0] c_sext;
   logic        r_out, con_en, pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   branch_sequencer dut (
      .clk       (clk),
      .clear     (clear),
      .start     (start),
      .ir        (ir),
      .condition (condition),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal),
      .ra_sel    (ra_sel),
      .c2        (c2),
      .c_sext    (c_sext),
      .r_out     (r_out),
      .con_en    (con_en),
      .pc_out    (pc_out),
      .y_in      (y_in),
      .c_out     (c_out),
      .alu_add   (alu_add),
      .z_in      (z_in),
      .zlo_out   (zlo_out),
      .pc_in     (pc_in),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: cycles_left counts down 4..1 through a branch
   // (4 = Ra/CON cycle, 1 = final Z->PC cycle); err_cyc marks the illegal pulse.
   int          cycles_left = 0;
   bit          err_cyc     = 0;
   bit          model_valid = 0;
   logic [3:0]  m_ra = '0, m_c2 = '0;
   logic [31:0] m_cs = '0;

   always @(posedge clk) begin
      if (clear) begin
         cycles_left = 0;
         err_cyc     = 0;
         m_ra        = '0;
         m_c2        = '0;
         m_cs        = '0;
         model_valid = 1;
      end else if (err_cyc) begin
         err_cyc = 0;
      end else if (cycles_left > 1) begin
         cycles_left = cycles_left - 1;
      end else if (start) begin
         if (ir[31:27] == 5'b10010) begin
            cycles_left = 4;
            m_ra = ir[26:23];
            m_c2 = ir[22:19];
            m_cs = {{13{ir[18]}}, ir[18:0]};
         end else begin
            cycles_left = 0;
            err_cyc     = 1;
         end
      end else begin
         cycles_left = 0;
      end
   end

   // compare process
   always @(negedge clk) begin
      if (model_valid) begin
         chk("busy",    32'(busy),    32'(cycles_left > 0));
         chk("done",    32'(done),    32'(cycles_left == 1));
         chk("illegal", 32'(illegal), 32'(err_cyc));
         chk("r_out",   32'(r_out),   32'(cycles_left == 4));
         chk("con_en",  32'(con_en),  32'(cycles_left == 4));
         chk("pc_out",  32'(pc_out),  32'(cycles_left == 3));
         chk("y_in",    32'(y_in),    32'(cycles_left == 3));
         chk("c_out",   32'(c_out),   32'(cycles_left == 2));
         chk("alu_add", 32'(alu_add), 32'(cycles_left == 2));
         chk("z_in",    32'(z_in),    32'(cycles_left == 2));
         chk("zlo_out", 32'(zlo_out), 32'(cycles_left == 1));
         chk("pc_in",   32'(pc_in),   32'((cycles_left == 1) && condition));
         chk("ra_sel",  32'(ra_sel),  32'(m_ra));
         chk("c2",      32'(c2),      32'(m_c2));
         chk("c_sext",  c_sext,       m_cs);
         chk("bus_one_driver", 32'($countones({r_out, pc_out, c_out, zlo_out}) <= 1), 32'd1);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_branch(input logic [31:0] instr, input logic cond_v);
      start = 1'b1;
      ir    = instr;
      tick();                          // T3
      start     = 1'b0;
      condition = ~cond_v;             // must not matter outside T6
      chk("t3_r_out",  32'(r_out),  32'd1);
      chk("t3_con_en", 32'(con_en), 32'd1);
      tick();                          // T4
      tick();                          // T5
      condition = cond_v;
      tick();                          // T6
      chk("t6_done",  32'(done),  32'd1);
      chk("t6_pc_in", 32'(pc_in), 32'(cond_v));
      tick();                          // IDLE
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   int done_cnt;

   initial begin
      clear     = 1'b1;
      start     = 1'b0;
      ir        = '0;
      condition = 1'b0;
      tick();
      tick();
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_c_sext", c_sext,      32'd0);
      chk("rst_ra_sel", 32'(ra_sel), 32'd0);
      clear = 1'b0;
      tick();

      // taken branch
      run_branch(32'h9088_0010, 1'b1);
      chk("taken_c_sext", c_sext,      32'h0000_0010);
      chk("taken_c2",     32'(c2),     32'h1);
      chk("taken_ra",     32'(ra_sel), 32'h1);

      // not taken
      run_branch(32'h9088_0010, 1'b0);

      // negative offset
      run_branch({5'b10010, 4'h3, 4'h2, 19'h7FFFC}, 1'b1);
      chk("neg_c_sext", c_sext,      32'hFFFF_FFFC);
      chk("neg_ra",     32'(ra_sel), 32'h3);

      // illegal opcode: pulse, no strobes, fields unchanged
      start = 1'b1;
      ir    = {5'b00011, 27'h0123456};
      tick();
      start = 1'b0;
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_busy",  32'(busy),    32'd0);
      chk("ill_keep",  c_sext,       32'hFFFF_FFFC);
      tick();
      chk("ill_end", 32'(illegal), 32'd0);
      tick();

      // back-to-back with start held high
      start     = 1'b1;
      ir        = {5'b10010, 4'h5, 4'h4, 19'h00020};
      condition = 1'b1;
      done_cnt  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) done_cnt++;
      end
      chk("b2b_done_cnt", 32'(done_cnt), 32'd3);
      // illegal start taken from T6
      ir = {5'b00011, 27'h0};
      tick();
      start = 1'b0;
      chk("t6_ill_pulse", 32'(illegal), 32'd1);
      tick();
      tick();

      // start pulse during T4 is ignored
      start = 1'b1;
      ir    = {5'b10010, 4'h6, 4'h1, 19'h00004};
      tick();                          // T3
      start = 1'b0;
      tick();                          // T4
      start = 1'b1;
      ir    = {5'b10010, 4'h7, 4'h7, 19'h00008};
      tick();                          // T5
      start = 1'b0;
      chk("ign_ra", 32'(ra_sel), 32'h6);
      tick();                          // T6
      tick();                          // IDLE
      chk("ign_idle", 32'(busy), 32'd0);

      // clear in T5
      start     = 1'b1;
      ir        = {5'b10010, 4'h9, 4'h3, 19'h00100};
      condition = 1'b1;
      tick();                          // T3
      start = 1'b0;
      tick();                          // T4
      tick();                          // T5
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy",   32'(busy),   32'd0);
      chk("clr_pc_in",  32'(pc_in),  32'd0);
      chk("clr_done",   32'(done),   32'd0);
      chk("clr_c_sext", c_sext,      32'd0);
      chk("clr_ra",     32'(ra_sel), 32'd0);
      tick();
      chk("clr_pc_in2", 32'(pc_in), 32'd0);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control FSM that sequences a conditional-branch instruction (brzr/brnz/brpl/brmi) through the single-bus datapath around the CON flip-flop. On a start it latches the instruction fields and, one step per cycle, drives Ra onto the bus with CON FF capture enabled. It then computes PC + sign-extended C through Y/ALU/Z, and loads PC from Z only if the registered branch condition is true. It sits between the instruction-decode step and the datapath select lines; the CON FF itself stays external.

## Interface
- BR_OPCODE, 5'b10010 — opcode value identifying a conditional branch.
- clk  in  1  datapath clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  request to execute the instruction on `ir`; sampled in IDLE or T6 only.
- ir  in  32  instruction: opcode[31:27], Ra[26:23], C2[22:19], C[18:0].
- condition  in  1  registered output of the external CON FF.
- busy  out  1  high in T3–T6.
- done  out  1  one-cycle pulse in T6.
- illegal  out  1  one-cycle pulse, the cycle after a start with a non-branch opcode.
- ra_sel  out  4  latched Ra, to the register-select logic.
- c2  out  4  latched C2, to the CON FF.
- c_sext  out  32  latched C sign-extended from bit 18.
- r_out  out  1  drive register ra_sel onto the bus.
- con_en  out  1  CON FF capture enable.
- pc_out, y_in, c_out, alu_add, z_in, zlo_out, pc_in  out  1 each  datapath strobes.

## Operation
- States: IDLE, T3, T4, T5, T6, ERR. Moore outputs decoded from state only.
- IDLE:
  - start & opcode==BR_OPCODE → T3; latch ra_sel, c2, c_sext.
  - start & other opcode → ERR.
  - No start → stay in IDLE.
- T3: r_out=1, con_en=1. The CON FF captures at the end of T3.
- T4: pc_out=1, y_in=1.
- T5: c_out=1, alu_add=1, z_in=1.
- T6: zlo_out=1, done=1, pc_in=condition. The condition reflects the T3 capture.
  - start & branch opcode → T3, with fields relatched (back-to-back).
  - start & other opcode → ERR.
  - Otherwise → IDLE.
- ERR: illegal=1, then IDLE. No datapath strobe is asserted.
- start is ignored in T3–T5 and ERR.
- At most one bus driver is asserted per cycle: r_out, pc_out, c_out, zlo_out are mutually exclusive.
- c_sext = {{13{ir[18]}}, ir[18:0]}.

## Timing
- Start sampled at edge k (IDLE) → T3 during cycle k+1, T4 k+2, T5 k+3, T6 k+4. Back in IDLE at k+5 if there is no new start.
- Latency start→done: 4 cycles. Back-to-back throughput: one branch per 4 cycles.
- Reset values: state=IDLE; all strobes, busy, done, illegal = 0; ra_sel, c2 = 0; c_sext = 0.
- clear has priority over start. clear mid-operation (any state) → IDLE next edge, all strobes 0 that cycle onward, pc_in never asserted.
- The condition input is only consumed in T6. Changes on it in other states have no effect.
- Field outputs hold their latched value until the next accepted start or clear.

## Structure
- Shared package holds:
  - state encoding (3-bit localparams IDLE..ERR),
  - BR_OPCODE,
  - instruction field bit positions (OPC_MSB/LSB, RA_MSB/LSB, C2_MSB/LSB, C_MSB).
- Single module: a state register, next-state logic, and an output decode block. No sub-module; the CON FF and its decoder remain separate instances in the datapath.

## Test plan
- Branch taken: ir=32'h9088_0010 (op 10010, Ra=1, C2=01, C=0x10), condition=1 in T6 → r_out/con_en in T3, pc_in=1 and done=1 in T6, c_sext=32'h0000_0010, c2=4'h1.
- Branch not taken: same ir, condition=0 in T6 → pc_in=0, done=1, return to IDLE next cycle.
- Negative offset: C=19'h7FFFC → c_sext=32'hFFFF_FFFC.
- Illegal opcode: ir[31:27]=5'b00011, start=1 → illegal pulses one cycle, no strobes asserted, busy stays 0.
- Back-to-back and ignored start:
  - start held high continuously → T3,T4,T5,T6,T3…, with done every 4th cycle.
  - start pulses in T4 are ignored.
- Reset mid-op: clear asserted in T5 → IDLE next cycle, pc_in never asserted, all outputs at reset values.
